uart_frame_writer: RTL and testbench
====================================

UART_FRAME_WRITER -- requirements
Module: uart_frame_writer

Interface
REQ-001 The block SHALL have parameter FRAME_PIXELS, default 307200, pixels per frame (640x480).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in clk_uart cycles.
REQ-004 The block SHALL have port clk_uart, input, 1, single clock for all logic, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rx_valid, input, 1, one-cycle strobe marking a received UART byte.
REQ-007 The block SHALL have port rx_data, input, 8, received byte, valid when rx_valid=1.
REQ-008 The block SHALL have port write_en, output, 1, RAM write strobe, one cycle per pixel.
REQ-009 The block SHALL have port addr_wr, output, 19, RAM write address.
REQ-010 The block SHALL have port write_data, output, 12, RAM write pixel {R[3:0],G[3:0],B[3:0]}.
REQ-011 The block SHALL have port busy, output, 1, high while a frame is in progress (state not IDLE).
REQ-012 The block SHALL have port frame_done, output, 1, one-cycle pulse on the final pixel write of a frame.
REQ-013 The block SHALL have port err_timeout, output, 1, one-cycle pulse when a frame is aborted by timeout.

Function
REQ-014 The block SHALL implement states IDLE, HI (await first pixel byte) and LO (await second pixel byte).
REQ-015 In IDLE, the block SHALL ignore rx_valid bytes that differ from SYNC_BYTE.
REQ-016 In IDLE, rx_valid with rx_data==SYNC_BYTE SHALL move the block to HI and clear the internal pixel address to 0.
REQ-017 In HI, rx_valid SHALL latch rx_data[3:0] as the red nibble, discard rx_data[7:4] and move to LO.
REQ-018 In LO, rx_valid SHALL cause write_en=1 on the following cycle, with write_data={red,rx_data[7:0]} and addr_wr equal to the current pixel address.
REQ-019 Pixel write latency SHALL be exactly 1 clk_uart cycle from the LO-state rx_valid to write_en.
REQ-020 addr_wr and write_data SHALL remain stable from their write_en cycle until the next write_en.
REQ-021 The pixel address SHALL increment by 1 after each write and SHALL never exceed FRAME_PIXELS-1.
REQ-022 A write at address FRAME_PIXELS-1 SHALL assert frame_done in the same cycle as its write_en and return the block to IDLE.
REQ-023 Any other LO-state write SHALL return the block to HI.
REQ-024 SYNC_BYTE received in HI or LO SHALL be treated as pixel data, with no resynchronisation.
REQ-025 rx_valid asserted on consecutive cycles SHALL be accepted each cycle, with no byte dropped.
REQ-026 busy SHALL be 1 in HI and LO and 0 in IDLE.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force state IDLE, pixel address 0, red nibble 0, write_en=0, addr_wr=0, write_data=0, busy=0, frame_done=0 and err_timeout=0.
REQ-028 Reset mid-frame SHALL discard any partial pixel and SHALL produce no write_en pulse.
REQ-029 After rst_n is released, the first rising clk_uart edge SHALL be processed normally.

Configuration
REQ-030 When macro UART_FRAME_TIMEOUT_EN is defined, an idle counter SHALL clear on every accepted byte in HI/LO, and on reaching TIMEOUT_CYCLES without a byte SHALL return the block to IDLE.
REQ-031 On that timeout, the block SHALL pulse err_timeout for 1 cycle, discard any partial pixel and assert no frame_done.
REQ-032 When UART_FRAME_TIMEOUT_EN is undefined, the block SHALL have no timeout counter, err_timeout SHALL be tied to 0, and HI/LO SHALL wait indefinitely.

Verification
REQ-033 The bench SHALL drive bytes 0x12, 0xA5, 0x3F, 0xAB after reset and SHALL check for exactly one write_en with addr_wr=0, write_data=12'hFAB, and busy=1 from the cycle after 0xA5.
REQ-034 The bench SHALL set FRAME_PIXELS=4, drive SYNC then 8 data bytes, and SHALL check addresses 0,1,2,3, frame_done coincident with the addr 3 write, and busy=0 afterwards.
REQ-035 The bench SHALL drive SYNC then bytes 0xA5, 0xA5 and SHALL check for one write with write_data=12'h5A5 (no resync).
REQ-036 The bench SHALL drive back-to-back rx_valid for 6 cycles after SYNC and SHALL check 3 writes at addr 0..2 with no dropped byte.
REQ-037 The bench SHALL assert rst_n=0 after SYNC and one pixel byte, then release it, and SHALL check all outputs are 0, state is IDLE, and no write_en occurs.
REQ-038 With UART_FRAME_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, the bench SHALL drive SYNC then 0x01 and wait 16 cycles, and SHALL check for a single err_timeout pulse, busy=0, and no write_en.

Source files
------------

// File: rtl/uart_frame_writer_if.sv
// Bundle of the UART byte stream and the pixel RAM write port of uart_frame_writer.
// Handshake: rx_valid is a one-cycle strobe and rx_data is only meaningful when it is high; there is no ready, so every strobe must be taken.
interface uart_frame_writer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        write_en;
  logic [18:0] addr_wr;
  logic [11:0] write_data;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  modport master (
    output rx_valid, rx_data,
    input  write_en, addr_wr, write_data, busy, frame_done, err_timeout
  );

  modport slave (
    input  rx_valid, rx_data,
    output write_en, addr_wr, write_data, busy, frame_done, err_timeout
  );
endinterface

// File: rtl/uart_frame_writer.sv
// Assembles SYNC-prefixed UART byte pairs into 12-bit pixels and writes them to a frame RAM.
// Optional inter-byte timeout abort is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_writer #(
  parameter int         FRAME_PIXELS   = 307200,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk_uart,
  input  logic               rst_n,
  uart_frame_writer_if.slave bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  localparam logic [18:0] LAST_ADDR = 19'(FRAME_PIXELS - 1);

  state_t      state, state_nxt;
  logic [18:0] pix_addr, addr_nxt;
  logic [3:0]  red, red_nxt;
  logic        wr_nxt, last_nxt;
  logic        write_en_q, frame_done_q;
  logic [18:0] addr_wr_q;
  logic [11:0] write_data_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int          TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt;
  logic          tmo_nxt, err_timeout_q;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = pix_addr;
    red_nxt   = red;
    wr_nxt    = 1'b0;
    last_nxt  = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
        state_nxt = HI;
        addr_nxt  = '0;
      end
      HI: if (bus.rx_valid) begin
        red_nxt   = bus.rx_data[3:0];
        state_nxt = LO;
      end
      LO: if (bus.rx_valid) begin
        wr_nxt = 1'b1;
        if (pix_addr == LAST_ADDR) begin
          last_nxt  = 1'b1;
          state_nxt = IDLE;
          addr_nxt  = '0;
        end else begin
          addr_nxt  = pix_addr + 19'd1;
          state_nxt = HI;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    // Abort only when this cycle carries no byte; a byte on the deadline cycle still counts.
    if (state != IDLE && !bus.rx_valid && idle_cnt == TO_LAST) begin
      state_nxt = IDLE;
      red_nxt   = '0;
      tmo_nxt   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pix_addr     <= '0;
      red          <= '0;
      write_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      addr_wr_q    <= '0;
      write_data_q <= '0;
    end else begin
      state        <= state_nxt;
      pix_addr     <= addr_nxt;
      red          <= red_nxt;
      write_en_q   <= wr_nxt;
      frame_done_q <= last_nxt;
      // Address and data hold between strobes so the RAM side can sample late.
      if (wr_nxt) begin
        addr_wr_q    <= pix_addr;
        write_data_q <= {red, bus.rx_data};
      end
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= tmo_nxt;
      if (state == IDLE || bus.rx_valid || tmo_nxt) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + 1'b1;
    end
  end
  assign bus.err_timeout = err_timeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.write_en   = write_en_q;
  assign bus.addr_wr    = addr_wr_q;
  assign bus.write_data = write_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer built with FRAME_PIXELS=4 and TIMEOUT_CYCLES=16.
module tb_uart_frame_writer;
  logic       clk_uart = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] state_dbg;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  logic [31:0] exp_q[$];

  uart_frame_writer_if bus ();

  uart_frame_writer #(
    .FRAME_PIXELS  (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_uart (clk_uart),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each observed write is {frame_done, addr_wr, write_data} against the expected queue.
  always @(negedge clk_uart) begin
    if (rst_n && bus.write_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", {bus.frame_done, bus.addr_wr, bus.write_data}, 32'hFFFF_FFFF);
      else chk("write", {bus.frame_done, bus.addr_wr, bus.write_data}, exp_q.pop_front());
    end
    if (rst_n && bus.frame_done) chk("frame_done_with_write", 32'(bus.write_en), 32'd1);
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk_uart);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle();
    @(negedge clk_uart);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    idle();
  endtask

  function automatic logic [31:0] pix(input logic last, input logic [18:0] a, input logic [11:0] d);
    return {last, a, d};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_write_en"},    32'(bus.write_en),    32'd0);
    chk({tag, "_addr_wr"},     32'(bus.addr_wr),     32'd0);
    chk({tag, "_write_data"},  32'(bus.write_data),  32'd0);
    chk({tag, "_busy"},        32'(bus.busy),        32'd0);
    chk({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
    chk({tag, "_state"},       32'(state_dbg),       32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_uart);
    rst_n = 1'b0;
    @(negedge clk_uart);
    rst_n = 1'b1;
  endtask

  initial begin
    int wr0, tmo_pulses, fd_pulses, wr_in_win;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk_uart);
    rst_n = 1'b1;

    // Junk byte ignored, SYNC starts a frame, one pixel 0x3F,0xAB -> FAB at addr 0
    wr0 = wr_cnt;
    send(8'h12);
    chk("junk_busy", 32'(bus.busy), 32'd0);
    send(8'hA5);
    chk("sync_busy", 32'(bus.busy), 32'd1);
    chk("sync_state", 32'(state_dbg), 32'd1);
    send(8'h3F);
    chk("lo_state", 32'(state_dbg), 32'd2);
    exp_q.push_back(pix(1'b0, 19'd0, 12'hFAB));
    drive(8'hAB);
    idle();
    chk("latency_write_en", 32'(bus.write_en), 32'd1);
    chk("latency_data", 32'(bus.write_data), 32'hFAB);
    repeat (3) idle();
    chk("one_write", 32'(wr_cnt - wr0), 32'd1);
    chk("hold_data", 32'(bus.write_data), 32'hFAB);
    chk("busy_after_pixel", 32'(bus.busy), 32'd1);
    do_reset();

    // Full 4-pixel frame
    wr0 = wr_cnt;
    send(8'hA5);
    exp_q.push_back(pix(1'b0, 19'd0, 12'h123));
    exp_q.push_back(pix(1'b0, 19'd1, 12'h456));
    exp_q.push_back(pix(1'b0, 19'd2, 12'h789));
    exp_q.push_back(pix(1'b1, 19'd3, 12'hABC));
    send(8'h01); send(8'h23);
    send(8'h04); send(8'h56);
    send(8'h07); send(8'h89);
    send(8'h0A); send(8'hBC);
    repeat (3) idle();
    chk("frame_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("frame_busy_after", 32'(bus.busy), 32'd0);
    chk("frame_state_after", 32'(state_dbg), 32'd0);
    chk("frame_hold_addr", 32'(bus.addr_wr), 32'd3);
    chk("frame_hold_data", 32'(bus.write_data), 32'hABC);

    // SYNC value inside a frame is plain pixel data
    wr0 = wr_cnt;
    send(8'hA5);
    exp_q.push_back(pix(1'b0, 19'd0, 12'h5A5));
    send(8'hA5);
    send(8'hA5);
    repeat (2) idle();
    chk("noresync_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("noresync_state", 32'(state_dbg), 32'd1);
    do_reset();

    // Back-to-back strobes, no bytes dropped
    wr0 = wr_cnt;
    exp_q.push_back(pix(1'b0, 19'd0, 12'h122));
    exp_q.push_back(pix(1'b0, 19'd1, 12'h344));
    exp_q.push_back(pix(1'b0, 19'd2, 12'h566));
    drive(8'hA5);
    drive(8'h11); drive(8'h22);
    drive(8'h33); drive(8'h44);
    drive(8'h55); drive(8'h66);
    repeat (3) idle();
    chk("b2b_writes", 32'(wr_cnt - wr0), 32'd3);
    do_reset();

    // Reset in the middle of a pixel
    wr0 = wr_cnt;
    send(8'hA5);
    send(8'h3C);
    @(negedge clk_uart);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk_uart);
    rst_n = 1'b1;
    repeat (3) idle();
    check_zero("after_midreset");
    chk("midreset_no_write", 32'(wr_cnt - wr0), 32'd0);

    // First edge after release is live: SYNC, then one byte, then silence
    send(8'hA5);
    chk("post_reset_busy", 32'(bus.busy), 32'd1);
    send(8'h01);
    wr0 = wr_cnt;
    tmo_pulses = 0;
    fd_pulses  = 0;
    wr_in_win  = 0;
    repeat (24) begin
      @(negedge clk_uart);
      if (bus.err_timeout) tmo_pulses++;
      if (bus.frame_done)  fd_pulses++;
      if (bus.write_en)    wr_in_win++;
    end
`ifdef UART_FRAME_TIMEOUT_EN
    chk("timeout_pulses", 32'(tmo_pulses), 32'd1);
    chk("timeout_busy", 32'(bus.busy), 32'd0);
    chk("timeout_state", 32'(state_dbg), 32'd0);
`else
    chk("no_timeout_pulses", 32'(tmo_pulses), 32'd0);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    chk("wait_state", 32'(state_dbg), 32'd2);
`endif
    chk("silence_frame_done", 32'(fd_pulses), 32'd0);
    chk("silence_no_write", 32'(wr_in_win), 32'd0);
    chk("silence_write_cnt", 32'(wr_cnt - wr0), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
